// File: rtl/gate_response_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker_pkg
// Description : Shared gate function codes and checker FSM state encoding,
//               reusable by gate checkers and gate testbenches.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_response_checker_pkg;

  // Two-input gate function codes; 6 and 7 are reserved.
  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  // Checker run states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : gate_response_checker_pkg
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : gate_ref_model
// Description : Combinational expected output of a two-input gate for a given
//               function code. Reserved codes return ~y so every sample fails.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_ref_model
  import gate_response_checker_pkg::*;
(
  input  logic [2:0] func,
  input  logic       a,
  input  logic       b,
  input  logic       y,
  output logic       expected
);

  // Truth table lookup for the selected gate function.
  always_comb begin
    expected = ~y;
    case (func)
      GATE_AND:  expected = a & b;
      GATE_OR:   expected = a | b;
      GATE_NAND: expected = ~(a & b);
      GATE_NOR:  expected = ~(a | b);
      GATE_XOR:  expected = a ^ b;
      GATE_XNOR: expected = ~(a ^ b);
      default:   expected = ~y;
    endcase
  end

endmodule : gate_ref_model
`default_nettype wire

// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker
// Description : Checks a stream of {a,b,y} samples from a gate under test
//               against the truth table of a selected function; counts
//               passes/fails, tracks input coverage, captures the first
//               failing vector and reports done/pass/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int MAX_SAMPLES = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func_sel,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       coverage,
  output logic             first_fail_vld,
  output logic [2:0]       first_fail_vec,
  output logic             done,
  output logic             pass,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = MAX_SAMPLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] SAT_CNT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       func_q;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] total_inc;
  logic [3:0]       cov_nxt;
  logic             expected;
  logic             accept;
  logic             arm;
  logic             cov_full;
  logic             finish;

  gate_ref_model u_ref_model (
    .func     (func_q),
    .a        (a),
    .b        (b),
    .y        (y),
    .expected (expected)
  );

  assign s_ready   = (state == ST_RUN);
  assign accept    = s_valid && s_ready;
  assign arm       = start && (state != ST_RUN);
  assign cov_nxt   = coverage | (4'b0001 << {a, b});
  assign cov_full  = (cov_nxt == 4'hF);
  // The run can never exceed MAX_SAMPLES, so total itself never wraps.
  assign total_inc = total + ONE_CNT;
  assign finish    = accept && (cov_full || (total_inc == MAX_CNT));

  assign done = (state == ST_DONE);
  assign pass = done && (fail_cnt == '0) && (coverage == 4'hF);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start arms from IDLE/DONE, run ends on coverage or sample limit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)  state_nxt = ST_RUN;
      ST_RUN:  if (finish) state_nxt = ST_DONE;
      ST_DONE: if (start)  state_nxt = ST_RUN;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  // Run statistics: cleared when a run is armed, updated on each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q         <= GATE_AND;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      coverage       <= 4'h0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= 3'b000;
      total          <= '0;
      timeout        <= 1'b0;
    end else if (arm) begin
      func_q         <= func_sel;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      coverage       <= 4'h0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= 3'b000;
      total          <= '0;
      timeout        <= 1'b0;
    end else if (accept) begin
      if (y == expected) begin
        if (pass_cnt != SAT_CNT) pass_cnt <= pass_cnt + ONE_CNT;
      end else begin
        if (fail_cnt != SAT_CNT) fail_cnt <= fail_cnt + ONE_CNT;
        if (!first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_vec <= {a, b, y};
        end
      end
      coverage <= cov_nxt;
      total    <= total_inc;
      // Full coverage takes priority over the sample limit on the same edge.
      if (finish) timeout <= !cov_full;
    end
  end

endmodule : gate_response_checker
`default_nettype wire

// File: tb/tb_gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_response_checker
// Description : Randomized and directed self-checking bench for
//               gate_response_checker against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_response_checker;

  localparam int CNT_W       = 3;
  localparam int MAX_SAMPLES = 7;
  localparam int SAT         = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [2:0]       func_sel;
  logic             s_valid;
  logic             s_ready;
  logic             a, b, y;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic [3:0]       coverage;
  logic             first_fail_vld;
  logic [2:0]       first_fail_vec;
  logic             done, pass, timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state (one run = a set of counters, not an FSM).
  bit       m_run, m_done, m_timeout, m_ffv;
  int       m_func, m_pass, m_fail, m_total;
  bit [3:0] m_cov;
  bit [2:0] m_ffvec;

  gate_response_checker #(
    .CNT_W       (CNT_W),
    .MAX_SAMPLES (MAX_SAMPLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .func_sel       (func_sel),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .a              (a),
    .b              (b),
    .y              (y),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .coverage       (coverage),
    .first_fail_vld (first_fail_vld),
    .first_fail_vec (first_fail_vec),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected gate output; -1 marks a reserved code (sample always fails).
  function automatic int gate_fn(input int f, input bit ia, input bit ib);
    case (f)
      0: return int'(ia & ib);
      1: return int'(ia | ib);
      2: return int'(!(ia & ib));
      3: return int'(!(ia | ib));
      4: return int'(ia ^ ib);
      5: return int'(ia == ib);
      default: return -1;
    endcase
  endfunction

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_total = 0; m_cov = 4'h0;
    m_ffv = 0; m_ffvec = 3'b000; m_timeout = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_run = 0; m_done = 0; m_func = 0;
  endtask

  // Apply one clock edge worth of inputs to the model.
  task automatic model_edge();
    int  e;
    bit  ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_run) begin
      if (s_valid) begin
        e  = gate_fn(m_func, a, b);
        ok = (e >= 0) && (e == int'(y));
        if (ok) m_pass = (m_pass < SAT) ? m_pass + 1 : m_pass;
        else begin
          m_fail = (m_fail < SAT) ? m_fail + 1 : m_fail;
          if (!m_ffv) begin
            m_ffv = 1;
            m_ffvec = {a, b, y};
          end
        end
        m_cov[{a, b}] = 1'b1;
        m_total++;
        if (m_cov == 4'hF) begin
          m_run = 0; m_done = 1; m_timeout = 0;
        end else if (m_total == MAX_SAMPLES) begin
          m_run = 0; m_done = 1; m_timeout = 1;
        end
      end
    end else if (start) begin
      model_clear();
      m_run = 1; m_done = 0; m_func = int'(func_sel);
    end
  endtask

  task automatic compare_all();
    chk("s_ready",   32'(s_ready),        32'(m_run));
    chk("pass_cnt",  32'(pass_cnt),       32'(m_pass));
    chk("fail_cnt",  32'(fail_cnt),       32'(m_fail));
    chk("coverage",  32'(coverage),       32'(m_cov));
    chk("ff_vld",    32'(first_fail_vld), 32'(m_ffv));
    chk("ff_vec",    32'(first_fail_vec), 32'(m_ffv ? m_ffvec : 3'b000));
    chk("done",      32'(done),           32'(m_done));
    chk("pass",      32'(pass),           32'(m_done && m_fail == 0 && m_cov == 4'hF));
    chk("timeout",   32'(timeout),        32'(m_timeout));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_in();
    start = 0; s_valid = 0;
    a = 1'($urandom); b = 1'($urandom); y = 1'($urandom);
  endtask

  task automatic pulse_start(input int f);
    start = 1; func_sel = 3'(f);
    step();
    idle_in();
  endtask

  task automatic send(input bit sa, input bit sb, input bit sy);
    s_valid = 1; a = sa; b = sb; y = sy;
    step();
    idle_in();
  endtask

  task automatic mid_reset();
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    step();
    rst_n = 1;
  endtask

  initial begin
    int e;
    rst_n = 0; func_sel = 3'd0;
    idle_in();
    @(negedge clk);
    model_reset();
    compare_all();
    step();
    rst_n = 1;
    step();

    // NAND, all four combinations correct.
    pulse_start(2);
    send(0, 0, 1); send(0, 1, 1); send(1, 0, 1); send(1, 1, 0);
    chk("nand_ok_pass", 32'(pass), 32'd1);
    chk("nand_ok_cnt",  32'(pass_cnt), 32'd4);
    step();

    // NAND with two faults; first one captured.
    pulse_start(2);
    send(1, 1, 1); send(0, 1, 0); send(0, 0, 1); send(1, 0, 1);
    chk("nand_bad_fail", 32'(fail_cnt), 32'd2);
    chk("nand_bad_vec",  32'(first_fail_vec), 32'b111);
    chk("nand_bad_pass", 32'(pass), 32'd0);

    // AND, sample limit reached without coverage; further samples refused.
    pulse_start(0);
    for (int i = 0; i < MAX_SAMPLES; i++) send(0, 0, 0);
    chk("and_to_timeout", 32'(timeout), 32'd1);
    chk("and_to_cov",     32'(coverage), 32'b0001);
    send(0, 0, 0);
    chk("and_to_frozen",  32'(pass_cnt), 32'(MAX_SAMPLES));

    // XOR, all failing up to the counter ceiling, then restart from DONE.
    pulse_start(4);
    for (int i = 0; i < MAX_SAMPLES; i++) send(0, 0, 1);
    chk("xor_sat", 32'(fail_cnt), 32'(SAT));
    pulse_start(4);
    chk("restart_ready", 32'(s_ready), 32'd1);
    chk("restart_fail",  32'(fail_cnt), 32'd0);

    // Mid-run reset discards the run.
    send(1, 1, 0);
    mid_reset();
    chk("rst_ready", 32'(s_ready), 32'd0);

    // Reserved code fails every sample.
    pulse_start(7);
    send(1, 0, 0);
    chk("rsv_vec", 32'(first_fail_vec), 32'b100);
    step();

    // Randomized runs with gaps, stray starts and occasional resets.
    for (int r = 0; r < 80; r++) begin
      pulse_start(int'($urandom_range(0, 7)));
      for (int c = 0; c < 24; c++) begin
        s_valid  = ($urandom_range(0, 2) != 0);
        a        = 1'($urandom);
        b        = 1'($urandom);
        e        = gate_fn(m_func, a, b);
        y        = (e < 0 || $urandom_range(0, 6) == 0) ? 1'($urandom) : 1'(e);
        start    = ($urandom_range(0, 11) == 0);
        func_sel = 3'($urandom);
        if ($urandom_range(0, 199) == 0) begin
          idle_in();
          mid_reset();
        end else begin
          step();
        end
      end
      idle_in();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gate_response_checker
`default_nettype wire
